// File: rtl/lz_denorm.sv
// lz_denorm: re-inserts leading zeros into a normalized mantissa
// (out_data = in_mant >> in_lz) through a two-stage elastic pipeline.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_mant/in_lz
// input side; out_valid/out_ready/out_data/out_ovr output side.
// Optional macro LZ_DENORM_STICKY_EN adds out_sticky (OR of shifted-out
// bits). Stage 1 shifts by whole bytes, stage 2 by the remaining 0..7.
module lz_denorm #(
  parameter int WIDTH = 48,
  parameter int LZW   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mant,
  input  logic [LZW-1:0]   in_lz,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovr
`ifdef LZ_DENORM_STICKY_EN
  ,
  output logic             out_sticky
`endif
);

  localparam logic [LZW-1:0]   LZ_MAX = LZW'(WIDTH);
  localparam logic [WIDTH-1:0] ONES   = '1;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [2:0]       s1_fine;
  logic             s1_ovr;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic             s2_ovr;

  logic             s1_load;
  logic             s2_load;
  logic [LZW-1:0]   c_sh;
  logic [WIDTH-1:0] c_data;
  logic             c_ovr;
  logic [WIDTH-1:0] f_data;

  assign s2_load = s1_valid & (~s2_valid | out_ready);
  assign in_ready = ~s1_valid | ~s2_valid | out_ready;
  assign s1_load = in_valid & in_ready;

  // Byte-granular coarse shift; amounts >= WIDTH shift everything out.
  assign c_sh   = {in_lz[LZW-1:3], 3'b000};
  assign c_data = in_mant >> c_sh;
  assign c_ovr  = in_lz > LZ_MAX;
  assign f_data = s1_ovr ? '0 : (s1_data >> s1_fine);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_fine  <= '0;
      s1_ovr   <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_data  <= c_data;
        s1_fine  <= in_lz[2:0];
        s1_ovr   <= c_ovr;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_ovr   <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid <= 1'b1;
        s2_data  <= f_data;
        s2_ovr   <= s1_ovr;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

`ifdef LZ_DENORM_STICKY_EN
  logic c_stk;
  logic f_stk;
  logic s1_stk;
  logic s2_stk;

  // Low bits below the shift amount are the ones that fall off bit 0.
  assign c_stk = |(in_mant & ~(ONES << c_sh));
  assign f_stk = s1_stk | (|(s1_data & ~(ONES << s1_fine)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_stk <= 1'b0;
      s2_stk <= 1'b0;
    end else begin
      if (s1_load) s1_stk <= c_stk;
      if (s2_load) s2_stk <= f_stk;
    end
  end

  assign out_sticky = s2_stk;
`endif

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_ovr   = s2_ovr;

endmodule

// File: tb/tb_lz_denorm.sv
// tb_lz_denorm: randomized and directed stimulus for lz_denorm, checked
// against a queue-based reference model of the elastic pipeline.
module tb_lz_denorm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_mant;
  logic [5:0]  in_lz;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_data;
  logic        out_ovr;
`ifdef LZ_DENORM_STICKY_EN
  logic        out_sticky;
`endif

  lz_denorm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mant   (in_mant),
    .in_lz     (in_lz),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovr   (out_ovr)
`ifdef LZ_DENORM_STICKY_EN
    ,
    .out_sticky(out_sticky)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] data;
    logic        ovr;
    logic        stk;
    int          acc;
  } beat_t;

  beat_t       q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        last_acc;
  logic        stall_prev = 1'b0;
  logic [47:0] stall_data;
  logic        stall_ovr;
  logic [47:0] cur_m;
  logic [5:0]  cur_lz;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic beat_t model(input logic [47:0] m,
                                  input logic [5:0] lz, input int acc);
    beat_t b;
    logic [63:0] mm;
    logic [63:0] mask;
    int          n;
    n      = int'(lz);
    mm     = {16'h0, m};
    b.acc  = acc;
    b.ovr  = (n > 48);
    b.data = (n >= 48) ? 48'h0 : 48'(mm / (64'd1 << n));
    mask   = (n >= 48) ? 64'hFFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    b.stk  = (mm & mask) != 64'd0;
    return b;
  endfunction

  task automatic step(input logic iv, input logic [47:0] m,
                      input logic [5:0] lz, input logic ordy);
    beat_t h;
    logic  exp_ov;
    @(negedge clk);
    in_valid  = iv;
    in_mant   = m;
    in_lz     = lz;
    out_ready = ordy;
    #1;
    if (stall_prev) begin
      check("stall_data", 64'(out_data), 64'(stall_data));
      check("stall_ovr", 64'(out_ovr), 64'(stall_ovr));
    end
    check("in_ready", 64'(in_ready), 64'((q.size() < 2) || ordy));
    exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 2);
    check("out_valid", 64'(out_valid), 64'(exp_ov));
    if (out_valid && ordy && q.size() > 0) begin
      h = q.pop_front();
      check("out_data", 64'(out_data), 64'(h.data));
      check("out_ovr", 64'(out_ovr), 64'(h.ovr));
`ifdef LZ_DENORM_STICKY_EN
      check("out_sticky", 64'(out_sticky), 64'(h.stk));
`endif
    end
    stall_prev = out_valid && !ordy;
    stall_data = out_data;
    stall_ovr  = out_ovr;
    last_acc   = iv && in_ready;
    if (last_acc) q.push_back(model(m, lz, cyc));
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++)
      step(1'b0, 48'h0, 6'd0, 1'b1);
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic new_beat();
    cur_m  = 48'({$urandom(), $urandom()});
    cur_lz = 6'($urandom_range(0, 63));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_lz     = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_ovr", 64'(out_ovr), 64'd0);
`ifdef LZ_DENORM_STICKY_EN
    check("rst_out_sticky", 64'(out_sticky), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    step(1'b1, 48'h8000_0000_0000, 6'd0, 1'b1);
    step(1'b1, 48'hFFFF_FFFF_FFFF, 6'd13, 1'b1);
    step(1'b1, 48'h8123_4567_89AB, 6'd48, 1'b1);
    step(1'b1, 48'hFFFF_0000_0001, 6'd63, 1'b1);
    step(1'b1, 48'h8000_0000_0001, 6'd47, 1'b1);
    step(1'b1, 48'hC000_0000_0000, 6'd49, 1'b1);
    drain();

    for (int i = 0; i < 10; i++) begin
      cur_m = 48'({$urandom(), $urandom()}) | 48'h8000_0000_0000;
      step(1'b1, cur_m, 6'(i), 1'b1);
      check("stream_accept", 64'(last_acc), 64'd1);
    end
    drain();

    new_beat();
    for (int i = 0; i < 14; i++) begin
      step(1'b1, cur_m, cur_lz, !(i >= 3 && i < 8));
      if (last_acc) new_beat();
    end
    drain();

    new_beat();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, cur_m, cur_lz,
           $urandom_range(0, 3) != 0);
      if (last_acc) new_beat();
    end
    drain();

    for (int i = 0; i < 4; i++) begin
      new_beat();
      step(1'b1, cur_m, cur_lz, 1'b0);
    end
    check("full_before_rst", 64'(q.size()), 64'd2);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_data", 64'(out_data), 64'd0);
    q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 48'h0000_FFFF_0000, 6'd8, 1'b1);
    step(1'b0, 48'h0, 6'd0, 1'b1);
    step(1'b0, 48'h0, 6'd0, 1'b1);
    check("post_rst_drained", 64'(q.size()), 64'd0);
    drain();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
